ce_gen_frac: RTL

//   Multi-channel fractional clock-enable generator, all channels on clk_sys.

---
 rtl/ce_gen_frac.sv | 101 ++++++++++
 1 files changed

// File: rtl/ce_gen_frac.sv
// Multi-channel fractional clock-enable generator on clk_sys.
// Each channel emits single-cycle ce pulses at num/den of the clock rate via a phase accumulator.
module ce_gen_frac #(
  parameter int CHANNELS = 4,
  parameter int ACC_W    = 24,
  parameter logic [CHANNELS*ACC_W-1:0] INIT_NUM = {24'd1, 24'd1, 24'd192, 24'd1},
  parameter logic [CHANNELS*ACC_W-1:0] INIT_DEN = {24'd1, 24'd50, 24'd62500, 24'd6},
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic [CHANNELS-1:0] en,
  input  logic                align,
  input  logic                cfg_wr,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [ACC_W-1:0]    cfg_num,
  input  logic [ACC_W-1:0]    cfg_den,
  output logic [CHANNELS-1:0] ce,
  output logic [ACC_W-1:0]    cfg_rd_num,
  output logic [ACC_W-1:0]    cfg_rd_den
);

  logic [ACC_W-1:0]    num_r [CHANNELS];
  logic [ACC_W-1:0]    den_r [CHANNELS];
  logic [ACC_W-1:0]    acc   [CHANNELS];
  logic [CHANNELS-1:0] ce_r;
  logic [ACC_W:0]      nxt   [CHANNELS];
  logic                cfg_in_range;

  // Returns {fire, next_acc}. Invalid ratios (den 0 or num > den) collapse to 1/1.
  function automatic logic [ACC_W:0] acc_step(input logic [ACC_W-1:0] a,
                                              input logic [ACC_W-1:0] n,
                                              input logic [ACC_W-1:0] d);
    logic [ACC_W-1:0] n_eff;
    logic [ACC_W-1:0] d_eff;
    logic [ACC_W:0]   sum;
    logic [ACC_W:0]   diff;
    if (d == '0 || n > d) begin
      n_eff = ACC_W'(1);
      d_eff = ACC_W'(1);
    end else begin
      n_eff = n;
      d_eff = d;
    end
    sum  = {1'b0, a} + {1'b0, n_eff};
    diff = sum - {1'b0, d_eff};
    if (sum >= {1'b0, d_eff}) acc_step = {1'b1, diff[ACC_W-1:0]};
    else                      acc_step = {1'b0, sum[ACC_W-1:0]};
  endfunction

  assign cfg_in_range = (32'(cfg_ch) < CHANNELS);

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      nxt[i] = acc_step(acc[i], num_r[i], den_r[i]);
    end
  end

  // Stage p0: accumulator, ratio registers and registered ce
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        num_r[i] <= INIT_NUM[i*ACC_W +: ACC_W];
        den_r[i] <= INIT_DEN[i*ACC_W +: ACC_W];
        acc[i]   <= '0;
      end
      ce_r <= '0;
    end else if (align) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc[i] <= '0;
      end
      ce_r <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (cfg_wr && cfg_in_range && cfg_ch == CH_W'(i)) begin
          num_r[i] <= cfg_num;
          den_r[i] <= cfg_den;
          acc[i]   <= '0;
          ce_r[i]  <= 1'b0;
        end else if (en[i]) begin
          acc[i]   <= nxt[i][ACC_W-1:0];
          ce_r[i]  <= nxt[i][ACC_W];
        end else begin
          ce_r[i]  <= 1'b0;
        end
      end
    end
  end

  assign ce = ce_r;

  always_comb begin
    cfg_rd_num = '0;
    cfg_rd_den = '0;
    if (cfg_in_range) begin
      cfg_rd_num = num_r[cfg_ch];
      cfg_rd_den = den_r[cfg_ch];
    end
  end

endmodule
